// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame path: FSM state encoding,
// parity type constants and the legal oversampling ratios.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Bundle of the receiver's line, configuration and result signals.
// The slave side is the receiver; the master side drives the line and config.
interface uart_rx_frame_if #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) ();
   logic               RX_IN;
   logic               PAR_EN;
   logic               PAR_TYP;
   logic [PRESC_W-1:0] Prescale;
   logic [WIDTH-1:0]   P_DATA;
   logic               data_valid;
   logic               par_err;
   logic               stp_err;

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, Prescale,
      output P_DATA, data_valid, par_err, stp_err
   );

   modport master (
      output RX_IN, PAR_EN, PAR_TYP, Prescale,
      input  P_DATA, data_valid, par_err, stp_err
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a three-sample majority vote around mid-bit.
// The counter is loaded with 1 on start detection, since the detection cycle
// itself is edge 0 of the start bit; it idles at 0 while not running.
module uart_rx_sampler #(
   parameter int PRESC_W = 6
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_run,
   input  logic               i_start,
   input  logic [PRESC_W-1:0] i_presc,
   input  logic               i_rx,
   output logic               o_bit_done,
   output logic               o_sampled_bit,
   output logic               o_sample_valid
);
   localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
   localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

   logic [PRESC_W-1:0] r_edge_cnt;
   logic               r_s0;
   logic               r_s1;
   logic               r_bit;
   logic [PRESC_W-1:0] w_half;
   logic [PRESC_W-1:0] w_last;

   assign w_half = i_presc >> 1;
   assign w_last = i_presc - ONE;

   // Edge counter: 0..P-1 within each bit period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge_cnt <= '0;
      end else if (i_start) begin
         r_edge_cnt <= ONE;
      end else if (!i_run) begin
         r_edge_cnt <= '0;
      end else if (r_edge_cnt == w_last) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + ONE;
      end
   end

   // Capture samples at P/2-1 and P/2, vote with the live sample at P/2+1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s0  <= 1'b0;
         r_s1  <= 1'b0;
         r_bit <= 1'b0;
      end else begin
         if (r_edge_cnt == w_half - ONE) r_s0 <= i_rx;
         if (r_edge_cnt == w_half)       r_s1 <= i_rx;
         if (r_edge_cnt == w_half + ONE)
            r_bit <= (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
      end
   end

   assign o_bit_done     = i_run && (r_edge_cnt == w_last);
   assign o_sample_valid = i_run && (r_edge_cnt == w_half + TWO);
   assign o_sampled_bit  = r_bit;
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start qualification, LSB-first deserialisation,
// optional parity check, stop check and a one-cycle valid strobe.
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) (
   input  logic            CLK,
   input  logic            RST,
   uart_rx_frame_if.slave  bus
);
   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] BC_ONE   = BCW'(1);

   rx_state_t          r_state;
   logic               r_par_en;
   logic               r_par_typ;
   logic [PRESC_W-1:0] r_presc;
   logic [WIDTH-1:0]   r_shift;
   logic [BCW-1:0]     r_bit_cnt;
   logic               r_par_pend;
   logic               r_stp_pend;
   logic [WIDTH-1:0]   r_p_data;
   logic               r_valid;
   logic               r_par_err;
   logic               r_stp_err;

   logic               w_run;
   logic               w_start;
   logic [PRESC_W-1:0] w_presc;
   logic               w_bit_done;
   logic               w_sampled_bit;
   logic               w_sample_valid;
   logic               w_exp_par;

   // While idle the live ratio is used so the detection cycle counts correctly;
   // afterwards the frame runs on the ratio latched at detection.
   assign w_run     = (r_state != IDLE);
   assign w_presc   = (r_state == IDLE) ? bus.Prescale : r_presc;
   assign w_start   = !bus.RX_IN && ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));
   assign w_exp_par = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;

   uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
      .i_clk          (CLK),
      .i_rst_n        (RST),
      .i_run          (w_run),
      .i_start        (w_start),
      .i_presc        (w_presc),
      .i_rx           (bus.RX_IN),
      .o_bit_done     (w_bit_done),
      .o_sampled_bit  (w_sampled_bit),
      .o_sample_valid (w_sample_valid)
   );

   // Frame FSM with shift register, pending error flags and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_presc    <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_par_pend <= 1'b0;
         r_stp_pend <= 1'b0;
         r_p_data   <= '0;
         r_valid    <= 1'b0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!bus.RX_IN) begin
                  r_state    <= START;
                  r_par_en   <= bus.PAR_EN;
                  r_par_typ  <= bus.PAR_TYP;
                  r_presc    <= bus.Prescale;
                  r_bit_cnt  <= '0;
                  r_par_pend <= 1'b0;
                  r_stp_pend <= 1'b0;
                  r_par_err  <= 1'b0;
                  r_stp_err  <= 1'b0;
               end
            end
            START: begin
               if (w_sample_valid && w_sampled_bit) begin
                  r_state <= IDLE;
               end else if (w_bit_done) begin
                  r_state   <= DATA;
                  r_bit_cnt <= '0;
               end
            end
            DATA: begin
               if (w_sample_valid)
                  r_shift <= {w_sampled_bit, r_shift[WIDTH-1:1]};
               if (w_bit_done) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? PARITY : STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BC_ONE;
                  end
               end
            end
            PARITY: begin
               if (w_sample_valid && (w_sampled_bit != w_exp_par))
                  r_par_pend <= 1'b1;
               if (w_bit_done)
                  r_state <= STOP;
            end
            STOP: begin
               if (w_sample_valid && !w_sampled_bit)
                  r_stp_pend <= 1'b1;
               if (w_bit_done) begin
                  r_par_err <= r_par_pend;
                  r_stp_err <= r_stp_pend;
                  if (!r_par_pend && !r_stp_pend) begin
                     r_p_data <= r_shift;
                     r_valid  <= 1'b1;
                  end
                  if (!bus.RX_IN) begin
                     // Line already low: treat as the start of the next frame.
                     r_state    <= START;
                     r_par_en   <= bus.PAR_EN;
                     r_par_typ  <= bus.PAR_TYP;
                     r_presc    <= bus.Prescale;
                     r_par_pend <= 1'b0;
                     r_stp_pend <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.P_DATA     = r_p_data;
   assign bus.data_valid = r_valid;
   assign bus.par_err    = r_par_err;
   assign bus.stp_err    = r_stp_err;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: the driver queues expected words with
// their expected strobe cycle; a monitor checks every data_valid strobe.
module tb_uart_rx_frame;
   import uart_rx_pkg::*;

   typedef struct {
      logic [7:0] d;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   uart_rx_frame_if #(.WIDTH(8), .PRESC_W(6)) bus_if ();

   uart_rx_frame #(.WIDTH(8), .PRESC_W(6)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one full frame; each bit lasts p cycles starting at the current cycle (t0).
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic typ,
                             input logic pb, input logic sb, input int p, input logic good);
      int n;
      int t0;
      exp_t e;
      n = 10 + (pe ? 1 : 0);
      t0 = cyc;
      bus_if.PAR_EN   = pe;
      bus_if.PAR_TYP  = typ;
      bus_if.Prescale = 6'(p);
      if (good) begin
         e.d = d;
         e.cyc = t0 + n * p;
         q.push_back(e);
      end
      $display("send 0x%02h P=%0d pe=%0d typ=%0d pbit=%0d stop=%0d t0=%0d good=%0d",
               d, p, pe, typ, pb, sb, t0, good);
      bus_if.RX_IN = 1'b0;
      wait_cycles(p);
      for (int i = 0; i < 8; i++) begin
         bus_if.RX_IN = d[i];
         wait_cycles(p);
      end
      if (pe) begin
         bus_if.RX_IN = pb;
         wait_cycles(p);
      end
      bus_if.RX_IN = sb;
      wait_cycles(p);
      bus_if.RX_IN = 1'b1;
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus_if.data_valid === 1'b1) begin
         $display("valid P_DATA=0x%02h cycle=%0d", bus_if.P_DATA, cyc);
         if (q.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("p_data", {24'd0, bus_if.P_DATA}, {24'd0, e.d});
            chk("valid_cycle", cyc, e.cyc);
            chk("par_err_on_valid", {31'd0, bus_if.par_err}, 32'd0);
            chk("stp_err_on_valid", {31'd0, bus_if.stp_err}, 32'd0);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus_if.RX_IN    = 1'b1;
      bus_if.PAR_EN   = 1'b0;
      bus_if.PAR_TYP  = PAR_EVEN;
      bus_if.Prescale = 6'(PRESC_8);
      wait_cycles(3);
      chk("rst_p_data", {24'd0, bus_if.P_DATA}, 32'd0);
      chk("rst_valid", {31'd0, bus_if.data_valid}, 32'd0);
      chk("rst_par_err", {31'd0, bus_if.par_err}, 32'd0);
      chk("rst_stp_err", {31'd0, bus_if.stp_err}, 32'd0);
      rst_n = 1'b1;
      wait_cycles(5);

      // Good even-parity frame, strobe at t0+88.
      send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, PRESC_8, 1'b1);
      wait_cycles(16);

      // Odd parity expected 1, sent 0 -> parity error, data held.
      send_frame(8'hA5, 1'b1, PAR_ODD, 1'b0, 1'b1, PRESC_8, 1'b0);
      wait_cycles(16);
      chk("t2_par_err", {31'd0, bus_if.par_err}, 32'd1);
      chk("t2_stp_err", {31'd0, bus_if.stp_err}, 32'd0);
      chk("t2_p_data", {24'd0, bus_if.P_DATA}, 32'hA5);

      // Bad stop bit at P=16 -> stop error only.
      send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, PRESC_16, 1'b0);
      wait_cycles(48);
      chk("t3_stp_err", {31'd0, bus_if.stp_err}, 32'd1);
      chk("t3_par_err", {31'd0, bus_if.par_err}, 32'd0);
      chk("t3_p_data", {24'd0, bus_if.P_DATA}, 32'hA5);

      // Next good frame clears stop error at its start.
      fork
         send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_16, 1'b1);
         begin
            wait_cycles(3);
            chk("t3_stp_err_cleared", {31'd0, bus_if.stp_err}, 32'd0);
         end
      join
      wait_cycles(32);

      // Glitch: 3 low clocks at P=16 must be rejected silently.
      bus_if.Prescale = 6'(PRESC_16);
      bus_if.RX_IN = 1'b0;
      wait_cycles(3);
      bus_if.RX_IN = 1'b1;
      wait_cycles(40);
      chk("t4_par_err", {31'd0, bus_if.par_err}, 32'd0);
      chk("t4_stp_err", {31'd0, bus_if.stp_err}, 32'd0);
      chk("t4_p_data", {24'd0, bus_if.P_DATA}, 32'h5A);

      // Back-to-back frames at P=32, strobes 320 cycles apart.
      send_frame(8'h01, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_32, 1'b1);
      send_frame(8'hFE, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_32, 1'b1);
      wait_cycles(40);
      chk("t5_p_data", {24'd0, bus_if.P_DATA}, 32'hFE);

      // Reset during data bit 4 of 0x77, then a clean 0x12.
      bus_if.PAR_EN   = 1'b0;
      bus_if.Prescale = 6'(PRESC_8);
      $display("send 0x77 P=8 partial, reset during bit 4, t0=%0d", cyc);
      bus_if.RX_IN = 1'b0;
      wait_cycles(8);
      for (int i = 0; i < 4; i++) begin
         bus_if.RX_IN = (i == 3) ? 1'b0 : 1'b1;
         wait_cycles(8);
      end
      bus_if.RX_IN = 1'b1;
      wait_cycles(4);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_p_data", {24'd0, bus_if.P_DATA}, 32'd0);
      wait_cycles(1);
      rst_n = 1'b1;
      wait_cycles(30);
      chk("t6_p_data_after_rst", {24'd0, bus_if.P_DATA}, 32'd0);
      chk("t6_par_err", {31'd0, bus_if.par_err}, 32'd0);
      chk("t6_stp_err", {31'd0, bus_if.stp_err}, 32'd0);
      send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_8, 1'b1);
      wait_cycles(20);
      chk("t6_p_data", {24'd0, bus_if.P_DATA}, 32'h12);

      chk("scoreboard_empty", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
